// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART memory dump engine.
// The dump FSM states, serialiser frame constants and a byte-select helper live here.
package uart_dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIT_CNT_W      = 4;
  localparam int FRAME_BITS     = 10;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_LOAD,
    ST_BYTE,
    ST_NEXT,
    ST_CSUM,
    ST_CSUMW,
    ST_FIN
  } dumpState_e;

  // Little-endian byte pick: index 0 is bits 7:0.
  function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serialiser: 8N1 framing, DIV clock cycles per bit, LSB first.
// ready_o is also high in the final cycle of the stop bit so that a byte
// loaded then starts its start bit with no idle gap.
module uart_tx_byte
  import uart_dump_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(1);

  logic                 tx_q, tx_d;
  logic [8:0]           shiftReg_q, shiftReg_d;
  logic [BIT_CNT_W-1:0] bitsLeft_q, bitsLeft_d;
  logic [BAUD_W-1:0]    baudCnt_q, baudCnt_d;

  assign ready_o = (bitsLeft_q == '0) || ((bitsLeft_q == LAST_BIT) && (baudCnt_q == BAUD_LAST));
  assign tx_o    = tx_q;

  // Next-state: a load starts a fresh frame, otherwise step the baud counter and shift on bit boundaries.
  always_comb begin
    tx_d       = tx_q;
    shiftReg_d = shiftReg_q;
    bitsLeft_d = bitsLeft_q;
    baudCnt_d  = baudCnt_q;
    if (load_i && ready_o) begin
      tx_d       = START_BIT;
      shiftReg_d = {STOP_BIT, data_i};
      bitsLeft_d = FRAME_LEN;
      baudCnt_d  = '0;
    end else if (bitsLeft_q != '0) begin
      if (baudCnt_q == BAUD_LAST) begin
        baudCnt_d  = '0;
        bitsLeft_d = bitsLeft_q - LAST_BIT;
        if (bitsLeft_q != LAST_BIT) begin
          tx_d       = shiftReg_q[0];
          shiftReg_d = {STOP_BIT, shiftReg_q[8:1]};
        end
      end else begin
        baudCnt_d = baudCnt_q + BAUD_W'(1);
      end
    end
  end

  // Serialiser registers; reset drops any partial frame and parks the line high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q       <= STOP_BIT;
      shiftReg_q <= '1;
      bitsLeft_q <= '0;
      baudCnt_q  <= '0;
    end else begin
      tx_q       <= tx_d;
      shiftReg_q <= shiftReg_d;
      bitsLeft_q <= bitsLeft_d;
      baudCnt_q  <= baudCnt_d;
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// UART read-back engine: reads word_cnt words starting at base from program ROM
// (sel=0) or data memory (sel=1) and sends each as 4 little-endian bytes on tx_o.
// Optional feature macro UART_DUMP_CHECKSUM_EN appends one byte holding the
// mod-256 sum of all data bytes sent.
module uart_mem_dump
  import uart_dump_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 128_000,
  parameter int ADDR_W      = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              start_i,
  input  logic              sel_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic              dump_rd_o,
  output logic [ADDR_W:0]   dump_adr_o,
  input  logic [31:0]       dump_dat_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W+1)'(1);
  localparam logic [2:0]      ALL_BYTES = 3'(BYTES_PER_WORD);

`ifdef UART_DUMP_CHECKSUM_EN
  localparam dumpState_e END_STATE = ST_CSUM;
`else
  localparam dumpState_e END_STATE = ST_FIN;
`endif

  dumpState_e        state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [2:0]        byteIdx_q, byteIdx_d;
  logic [7:0]        csum_q, csum_d;
  logic              txLoad, txReady;
  logic [7:0]        txByte;

  assign dump_rd_o  = (state_q == ST_RD);
  assign dump_adr_o = {sel_q, addr_q};
  assign done_o     = (state_q == ST_FIN);
  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_FIN);

  uart_tx_byte #(.DIV(DIV)) txByteInst (
    .clk_i   (upg_clk_i),
    .rst_i   (upg_rst_i),
    .load_i  (txLoad),
    .data_i  (txByte),
    .ready_o (txReady),
    .tx_o    (tx_o)
  );

  // Dump sequencing: fetch a word, feed its bytes to the serialiser back-to-back, then advance.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    shreg_d     = shreg_q;
    byteIdx_d   = byteIdx_q;
    csum_d      = csum_q;
    txLoad      = 1'b0;
    txByte      = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sel_d       = sel_i;
          addr_d      = base_adr_i;
          remaining_d = word_cnt_i;
          csum_d      = 8'h00;
          state_d     = (word_cnt_i == '0) ? END_STATE : ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d   = dump_dat_i;
        txLoad    = 1'b1;
        txByte    = dump_dat_i[7:0];
        csum_d    = csum_q + dump_dat_i[7:0];
        byteIdx_d = 3'd1;
        state_d   = ST_BYTE;
      end
      ST_BYTE: begin
        if (txReady) begin
          if (byteIdx_q != ALL_BYTES) begin
            txLoad    = 1'b1;
            txByte    = wordByte(shreg_q, byteIdx_q[1:0]);
            csum_d    = csum_q + txByte;
            byteIdx_d = byteIdx_q + 3'd1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ONE_WORD;
        state_d     = (remaining_q == ONE_WORD) ? END_STATE : ST_RD;
      end
      ST_CSUM: begin
        txLoad  = 1'b1;
        txByte  = csum_q;
        state_d = ST_CSUMW;
      end
      ST_CSUMW: begin
        if (txReady) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      shreg_q     <= '0;
      byteIdx_q   <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      shreg_q     <= shreg_d;
      byteIdx_q   <= byteIdx_d;
      csum_q      <= csum_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump with DIV=16, a synchronous memory model and a UART receiver on tx_o.
// Expected values are hand-computed; UART_DUMP_CHECKSUM_EN selects the trailer-byte expectations.
module tb_uart_mem_dump;

`ifdef UART_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [13:0] base = '0;
  logic [14:0] cnt = '0;
  logic        dumpRd;
  logic [14:0] dumpAdr;
  logic [31:0] dumpDat = '0;
  logic        tx, busy, done;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int frameErr = 0;
  logic [14:0] adrLog[$];
  logic [7:0]  rxQ[$];
  logic        rxFlush = 1'b0;
  logic        rxActive = 1'b0;
  int          rxCnt = 0;
  logic [7:0]  rxShift = '0;

  always #5 clk = ~clk;

  uart_mem_dump #(.CLK_FREQ_HZ(16), .BAUD(1), .ADDR_W(14)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .start_i    (start),
    .sel_i      (sel),
    .base_adr_i (base),
    .word_cnt_i (cnt),
    .dump_rd_o  (dumpRd),
    .dump_adr_o (dumpAdr),
    .dump_dat_i (dumpDat),
    .tx_o       (tx),
    .busy_o     (busy),
    .done_o     (done)
  );

  function automatic logic [31:0] memWord(input logic [14:0] a);
    case (a)
      15'h0000: return 32'h12345678;
      15'h7FFF: return 32'hA1B2C3D4;
      15'h4000: return 32'h0BADF00D;
      15'h0010: return 32'h01020304;
      15'h0011: return 32'hFFFFFFFF;
      default:  return 32'hDEAD0000 ^ {17'h0, a};
    endcase
  endfunction

  // Synchronous memory: data appears after the read edge and holds until the next read.
  always @(posedge clk) begin
    if (dumpRd) dumpDat <= memWord(dumpAdr);
  end

  // Read-strobe and done monitors.
  always @(negedge clk) begin
    if (dumpRd) adrLog.push_back(dumpAdr);
    if (done) doneCount <= doneCount + 1;
  end

  // UART receiver: detects the start bit, samples mid-bit, checks the stop bit.
  always @(negedge clk) begin
    if (rxFlush) begin
      rxActive <= 1'b0;
    end else if (!rxActive) begin
      if (tx === 1'b0) begin
        rxActive <= 1'b1;
        rxCnt    <= 1;
      end
    end else begin
      rxCnt <= rxCnt + 1;
      if (rxCnt >= 24 && rxCnt <= 136 && ((rxCnt - 24) % 16) == 0) rxShift <= {tx, rxShift[7:1]};
      if (rxCnt == 152) begin
        rxActive <= 1'b0;
        rxQ.push_back(rxShift);
        if (tx !== 1'b1) frameErr <= frameErr + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [13:0] b, input logic [14:0] c);
    @(posedge clk); #1;
    sel = s; base = b; cnt = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k counts cycles after the accept edge, sampled at the falling edge.
  task automatic runDump(input logic s, input logic [13:0] b, input logic [14:0] c, input int restartAt,
                         output int firstLowK, output int doneK);
    applyStimulus(s, b, c);
    firstLowK = -1;
    doneK = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == restartAt) begin
        start = 1'b1; sel = 1'b1; base = 14'h3FFF; cnt = 15'd2;
      end else if (k == restartAt + 1) begin
        start = 1'b0;
      end
      if (firstLowK < 0 && tx === 1'b0) firstLowK = k;
      if (done === 1'b1) begin
        doneK = k;
        break;
      end
    end
    #1;
  endtask

  function automatic logic [63:0] rxPacked();
    logic [63:0] v = '0;
    for (int i = 0; i < rxQ.size() && i < 8; i++) v[8*i +: 8] = rxQ[i];
    return v;
  endfunction

  initial begin
    int firstLowK, doneK, doneBase;
    $display("[TB] uart_mem_dump bench, checksum trailer = %0d", CS);

    #12;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_rd", dumpRd, 1'b0);
    checkOutput("reset_adr", dumpAdr, 15'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Single word from program ROM.
    rxQ.delete(); adrLog.delete(); doneBase = doneCount;
    runDump(1'b0, 14'h0000, 15'd1, -1, firstLowK, doneK);
    checkOutput("A_first_start_edge", firstLowK, 3);
    checkOutput("A_done_cycle", doneK, 644 + 161 * CS);
    checkOutput("A_byte_count", rxQ.size(), 4 + CS);
    checkOutput("A_bytes", rxPacked(), 64'h12345678 | (CS ? 64'h14_0000_0000 : 64'h0));
    checkOutput("A_rd_count", adrLog.size(), 1);
    checkOutput("A_rd_adr", adrLog[0], 15'h0000);
    checkOutput("A_done_pulses", doneCount - doneBase, 1);
    checkOutput("A_idle_after", {busy, tx}, 2'b01);

    // Two words from data memory with address wrap.
    rxQ.delete(); adrLog.delete(); doneBase = doneCount;
    runDump(1'b1, 14'h3FFF, 15'd2, -1, firstLowK, doneK);
    checkOutput("B_done_cycle", doneK, 1288 + 161 * CS);
    checkOutput("B_rd_count", adrLog.size(), 2);
    checkOutput("B_adr0", adrLog[0], 15'h7FFF);
    checkOutput("B_adr1", adrLog[1], 15'h4000);
    checkOutput("B_byte_count", rxQ.size(), 8 + CS);
    checkOutput("B_bytes", rxPacked(), 64'h0BADF00D_A1B2C3D4);
`ifdef UART_DUMP_CHECKSUM_EN
    checkOutput("B_trailer", rxQ[8], 8'h9F);
`endif
    checkOutput("B_done_pulses", doneCount - doneBase, 1);

    // Zero-length dump.
    rxQ.delete(); adrLog.delete(); doneBase = doneCount;
    runDump(1'b0, 14'h0123, 15'd0, -1, firstLowK, doneK);
    checkOutput("C_done_cycle", doneK, 161 * CS);
    checkOutput("C_first_low", firstLowK, CS ? 1 : -1);
    checkOutput("C_rd_count", adrLog.size(), 0);
    checkOutput("C_byte_count", rxQ.size(), CS);
    checkOutput("C_bytes", rxPacked(), 64'h0);
    checkOutput("C_done_pulses", doneCount - doneBase, 1);

    // Second start mid-dump must be ignored.
    rxQ.delete(); adrLog.delete(); doneBase = doneCount;
    runDump(1'b0, 14'h0000, 15'd1, 100, firstLowK, doneK);
    checkOutput("D_done_cycle", doneK, 644 + 161 * CS);
    checkOutput("D_bytes", rxPacked(), 64'h12345678 | (CS ? 64'h14_0000_0000 : 64'h0));
    checkOutput("D_rd_count", adrLog.size(), 1);
    repeat (50) @(negedge clk);
    #1;
    checkOutput("D_done_pulses", doneCount - doneBase, 1);
    checkOutput("D_busy_after", busy, 1'b0);

    // Reset during the third data bit of the first byte.
    rxQ.delete(); adrLog.delete();
    applyStimulus(1'b0, 14'h0000, 15'd1);
    repeat (60) @(negedge clk);
    checkOutput("E_tx_in_bit2", tx, 1'b0);
    rst = 1'b1;
    rxFlush = 1'b1;
    #1;
    checkOutput("E_tx_async", tx, 1'b1);
    checkOutput("E_busy_async", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxFlush = 1'b0;
    rxQ.delete(); adrLog.delete(); doneBase = doneCount;
    runDump(1'b0, 14'h0000, 15'd1, -1, firstLowK, doneK);
    checkOutput("E_restart_done", doneK, 644 + 161 * CS);
    checkOutput("E_restart_bytes", rxPacked(), 64'h12345678 | (CS ? 64'h14_0000_0000 : 64'h0));
    checkOutput("E_done_pulses", doneCount - doneBase, 1);

    // Checksum example words.
    rxQ.delete(); adrLog.delete();
    runDump(1'b0, 14'h0010, 15'd2, -1, firstLowK, doneK);
    checkOutput("F_done_cycle", doneK, 1288 + 161 * CS);
    checkOutput("F_bytes", rxPacked(), 64'hFFFFFFFF_01020304);
    checkOutput("F_byte_count", rxQ.size(), 8 + CS);
`ifdef UART_DUMP_CHECKSUM_EN
    checkOutput("F_trailer", rxQ[8], 8'h06);
`endif
    checkOutput("frame_errors", frameErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
